// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the single-port memory bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_ALL = '1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2,
    ARB_DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one memory port between fetch and data; ack two cycles after the request at minimum.
// Requesters hold their request until ack and see a combinational stall while waiting; no queueing.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              bus_err,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [SEL_W-1:0]  bus_sel,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WD_W-1:0] WD_LAST_V = WD_W'(WD_LAST);
  localparam logic [3:0] STARVE_V = 4'(STARVE_MAX);

  arb_state_t state, state_n;
  arb_grant_t grant;
  logic [3:0]      starve_cnt;
  logic [WD_W-1:0] wdog;
  logic            err_flag;

  logic grant_d, grant_if, done_ok, done_to, wd_expire;

  assign wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST_V);

  always_comb begin
    state_n  = state;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_req && (!if_req || (starve_cnt < STARVE_V))) begin
          state_n = ARB_BUSY_D;
          grant_d = 1'b1;
        end else if (if_req) begin
          state_n  = ARB_BUSY_IF;
          grant_if = 1'b1;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_D: begin
        // A completion on the expiry cycle still wins over the timeout.
        if (bus_ack) begin
          state_n = ARB_DONE;
          done_ok = 1'b1;
        end else if (wd_expire) begin
          state_n = ARB_DONE;
          done_to = 1'b1;
        end
      end
      ARB_DONE: state_n = ARB_IDLE;
      default:  state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant      <= GRANT_IF;
      starve_cnt <= '0;
      wdog       <= '0;
      err_flag   <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_sel    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_n;
      if (grant_d) begin
        grant      <= GRANT_D;
        bus_req    <= 1'b1;
        bus_we     <= d_we;
        bus_addr   <= d_addr;
        bus_wdata  <= d_wdata;
        bus_sel    <= d_sel;
        wdog       <= '0;
        err_flag   <= 1'b0;
        starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
      end
      if (grant_if) begin
        grant      <= GRANT_IF;
        bus_req    <= 1'b1;
        bus_we     <= 1'b0;
        bus_addr   <= if_addr;
        bus_sel    <= SEL_ALL;
        wdog       <= '0;
        err_flag   <= 1'b0;
        starve_cnt <= 4'd0;
      end
      if ((state == ARB_BUSY_IF) || (state == ARB_BUSY_D)) begin
        wdog <= wdog + WD_W'(1);
      end
      if (done_ok || done_to) begin
        bus_req  <= 1'b0;
        err_flag <= done_to;
        if (grant == GRANT_IF) begin
          if_rdata <= done_ok ? bus_rdata : '0;
        end else begin
          d_rdata <= done_ok ? bus_rdata : '0;
        end
      end
    end
  end

  assign if_ack       = (state == ARB_DONE) && (grant == GRANT_IF);
  assign d_ack        = (state == ARB_DONE) && (grant == GRANT_D);
  assign bus_err      = (state == ARB_DONE) && err_flag;
  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed stimulus for bus_arbiter; acks are checked by a queue-driven monitor.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_err;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic expect_ack(input logic is_d, input logic [31:0] rd, input logic err);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rd;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack the DUT presents must match the oldest expected response.
  always @(negedge clk) begin
    if (if_ack || d_ack) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected no ack", if_ack, d_ack);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_port_is_d", {31'd0, d_ack}, {31'd0, mon_e.is_d});
        chk("ack_rdata", d_ack ? d_rdata : if_rdata, mon_e.rdata);
        chk("ack_bus_err", {31'd0, bus_err}, {31'd0, mon_e.err});
      end
    end
  end

  // Slave: wait (bounded) for a bus request, check its address, ack after dly BUSY cycles.
  task automatic serve(input string nm, input logic [31:0] exp_addr,
                       input logic [31:0] rd, input int dly);
    int n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus_req) begin
      n_total++;
      $display("FAIL %s_wait: got no bus_req after %0d cycles expected bus_req=1", nm, n);
    end else begin
      chk(nm, bus_addr, exp_addr);
      repeat (dly - 1) @(negedge clk);
      bus_ack   = 1'b1;
      bus_rdata = rd;
      @(negedge clk);
      bus_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int n;
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_sel = 0; bus_rdata = 0; bus_ack = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_acks", {29'd0, if_ack, d_ack, bus_err}, 32'd0);
    chk("rst_stalls", {30'd0, stallreq_if, stallreq_mem}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    rst = 1'b0;

    // Fetch only
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    expect_ack(1'b0, 32'h3C010101, 1'b0);
    #1 chk("f_stall_c0", {31'd0, stallreq_if}, 32'd1);
    @(negedge clk);
    chk("f_bus_addr", bus_addr, 32'h100);
    chk("f_bus_we_req", {30'd0, bus_we, bus_req}, 32'd1);
    chk("f_bus_sel", {28'd0, bus_sel}, 32'hF);
    chk("f_stall_c1", {31'd0, stallreq_if}, 32'd1);
    bus_ack = 1; bus_rdata = 32'h3C010101;
    @(negedge clk);
    chk("f_if_ack_c2", {31'd0, if_ack}, 32'd1);
    chk("f_stall_c2", {31'd0, stallreq_if}, 32'd0);
    bus_ack = 0; if_req = 0;

    // Collision: data wins
    @(negedge clk);
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_sel = 4'b0011;
    expect_ack(1'b1, 32'h11112222, 1'b0);
    expect_ack(1'b0, 32'h24020002, 1'b0);
    #1 chk("c_stalls_c0", {30'd0, stallreq_if, stallreq_mem}, 32'd3);
    @(negedge clk);
    chk("c_bus_addr", bus_addr, 32'h2000);
    chk("c_bus_we", {31'd0, bus_we}, 32'd1);
    chk("c_bus_wdata", bus_wdata, 32'hDEADBEEF);
    chk("c_bus_sel", {28'd0, bus_sel}, 32'h3);
    bus_ack = 1; bus_rdata = 32'h11112222;
    @(negedge clk);
    chk("c_d_ack_c2", {31'd0, d_ack}, 32'd1);
    chk("c_stall_if_c2", {31'd0, stallreq_if}, 32'd1);
    bus_ack = 0; d_req = 0;
    @(negedge clk);
    chk("c_idle_c3", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    chk("c_if_req_c4", {31'd0, bus_req}, 32'd1);
    chk("c_if_addr_c4", bus_addr, 32'h104);
    chk("c_if_we_c4", {31'd0, bus_we}, 32'd0);
    bus_ack = 1; bus_rdata = 32'h24020002;
    @(negedge clk);
    chk("c_if_ack_c5", {31'd0, if_ack}, 32'd1);
    bus_ack = 0; if_req = 0;

    // Starvation: four data grants, one fetch, then data again
    @(negedge clk);
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_sel = 4'hF;
    for (int i = 0; i < 6; i++) expect_ack(i != 4, 32'hA0000000 + i, 1'b0);
    for (int i = 0; i < 6; i++) begin
      serve($sformatf("s_grant%0d_addr", i), (i == 4) ? 32'h200 : 32'h3000,
            32'hA0000000 + i, 1);
      if (i == 4) if_req = 0;
      if (i == 5) d_req = 0;
    end

    // Timeout: no bus_ack ever
    @(negedge clk);
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 32'h4000; d_sel = 4'hF;
    expect_ack(1'b1, 32'h0, 1'b1);
    n = 0;
    @(negedge clk);
    while (bus_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t_busreq_cycles", n, 32'd16);
    chk("t_d_ack_err", {30'd0, d_ack, bus_err}, 32'd3);
    d_req = 0;

    // Ack on the expiry cycle is a success
    @(negedge clk);
    @(negedge clk);
    d_req = 1; d_addr = 32'h5000;
    expect_ack(1'b1, 32'h5A5A1234, 1'b0);
    repeat (16) @(negedge clk);
    chk("e_busreq_c16", {31'd0, bus_req}, 32'd1);
    bus_ack = 1; bus_rdata = 32'h5A5A1234;
    @(negedge clk);
    chk("e_d_ack_err", {30'd0, d_ack, bus_err}, 32'd2);
    bus_ack = 0; d_req = 0;

    // Stray bus_ack in IDLE is ignored
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 0;
    chk("i_busreq", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    chk("i_acks", {30'd0, if_ack, d_ack}, 32'd0);

    // Reset in the middle of a data access
    d_req = 1; d_addr = 32'h6000;
    repeat (3) @(negedge clk);
    chk("r_busreq_c3", {31'd0, bus_req}, 32'd1);
    rst = 1;
    @(negedge clk);
    chk("r_busreq_c4", {31'd0, bus_req}, 32'd0);
    chk("r_d_ack_c4", {31'd0, d_ack}, 32'd0);
    rst = 0; d_req = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h300;
    expect_ack(1'b0, 32'h00000077, 1'b0);
    serve("r_if_addr", 32'h300, 32'h00000077, 1);
    if_req = 0;

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external memory port between the instruction-fetch path (pc_reg/if_id) and the data-access path (mem stage), for a single-bus (von Neumann) build of the core.
- Grants one requester at a time with data priority and an IF anti-starvation rule.
- Registers every bus transaction and returns a one-cycle ack with read data.
- Raises per-requester stall requests for the pipeline control logic.

Parameters:
- ADDR_W, 32, address width (matches `InstAddrBus).
- DATA_W, 32, data width (matches `RegBus).
- STARVE_MAX, 4, maximum consecutive data grants while if_req is pending before IF must be granted; range 1..15.
- TIMEOUT, 16, bus_ack watchdog in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  core clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; valid when if_ack is high.
- if_ack  out  1  one-cycle fetch completion.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_sel  in  4  byte lane enables.
- d_rdata  out  DATA_W  read data; valid when d_ack is high.
- d_ack  out  1  one-cycle data completion.
- bus_err  out  1  one-cycle pulse with the ack of a timed-out transaction.
- stallreq_if  out  1  fetch is waiting.
- stallreq_mem  out  1  data access is waiting.
- bus_req  out  1  external port request; held until bus_ack.
- bus_we  out  1  external write enable.
- bus_addr  out  ADDR_W  external address.
- bus_wdata  out  DATA_W  external write data.
- bus_sel  out  4  external byte enables.
- bus_rdata  in  DATA_W  external read data; sampled when bus_ack is high.
- bus_ack  in  1  external completion, one cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0; watchdog counter 0.
- States:
  - IDLE: arbitrate.
  - BUSY_IF: fetch in flight.
  - BUSY_D: data access in flight.
  - DONE: acknowledge cycle.
- IDLE arbitration:
  - d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX) -> BUSY_D; starve_cnt increments if if_req=1, otherwise clears.
  - Otherwise if_req=1 -> BUSY_IF; starve_cnt clears.
  - Neither request -> stay in IDLE.
- On the grant edge, latch the granted requester's addr/we/wdata/sel onto the bus_* registers and set bus_req=1. IF grants drive bus_we=0 and bus_sel=4'b1111.
- BUSY_*:
  - bus_* outputs stay stable and the watchdog counts each cycle.
  - bus_ack=1 -> capture bus_rdata into the granted requester's rdata register, drop bus_req, go to DONE.
  - TIMEOUT!=0 and watchdog==TIMEOUT-1 with no bus_ack -> drop bus_req, force rdata to 0, set the error flag, go to DONE.
- DONE (exactly one cycle):
  - Assert the granted requester's ack, plus bus_err if flagged.
  - Requests are not sampled in DONE, so a requester can deassert or replace its request before the next IDLE sample.
  - Next state is IDLE.
- Latency: request in cycle 0, bus_req in cycle 1, bus_ack in cycle N (N>=1), ack in cycle N+1. Minimum is ack in cycle 2. Back-to-back transactions are separated by one IDLE cycle.
- rdata registers hold their value until the next capture for that requester.
- Stall outputs are combinational: stallreq_if = if_req & ~if_ack; stallreq_mem = d_req & ~d_ack.
- Simultaneous if_req and d_req in IDLE: data wins unless starve_cnt==STARVE_MAX.
- A request arriving while the other requester is BUSY waits in its stall; it is not lost.
- A bus_ack arriving in IDLE or DONE is ignored.
- A bus_ack in the same cycle the watchdog expires counts as success; bus_err stays 0.
- Reset during BUSY: the next edge gives IDLE, bus_req=0, no ack. The slave transaction is abandoned and the requester must re-request.
- Changing a request's fields while it is pending is illegal and not checked.

Decomposition:
- defines.v gains:
  - State codes `ArbIdle, `ArbBusyIf, `ArbBusyD, `ArbDone (2-bit `ArbStateBus).
  - `ByteSelBus (3:0).
  - `ArbGrantIf / `ArbGrantD.
- Reuse the existing `RegBus, `InstAddrBus, `WriteEnable and `ChipEnable defines.
- No sub-module; the watchdog and starvation counters are local registers.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, bus_ack in cycle 1 with bus_rdata=0x3C010101 -> bus_addr=0x100 and bus_we=0 in cycle 1; if_ack=1 and if_rdata=0x3C010101 in cycle 2; stallreq_if=1 in cycles 0-1.
- Collision: if_req and d_req (write, addr 0x2000, wdata 0xDEADBEEF, sel 4'b0011) both in cycle 0, bus_ack after 1 cycle each -> data granted first with bus_sel=0011 and d_ack in cycle 2; IDLE in cycle 3; IF bus_req in cycle 4.
- Starvation: d_req re-asserted continuously with if_req held, STARVE_MAX=4 -> exactly 4 data grants, then an IF grant, then data resumes.
- Timeout: TIMEOUT=16, d_req read, bus_ack never arrives -> bus_req drops after 16 cycles; next cycle d_ack=1, bus_err=1, d_rdata=0.
- Ack on expiry: bus_ack in the same cycle the watchdog expires -> success; bus_err=0, d_rdata=bus_rdata.
- Reset mid-op: rst=1 in cycle 3 of a BUSY_D wait -> cycle 4 has bus_req=0, state IDLE, no d_ack; a new if_req is then served normally.
